// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one pipelined alu32 between NREQ requesters.
// Issued ops are tagged through the ALU key; returning keys are matched to their owner.
module alu_arbiter #(
  parameter int NREQ    = 2,
  parameter int OP_W    = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*OP_W-1:0] req_op,
  input  logic [NREQ*32-1:0]   req_a,
  input  logic [NREQ*32-1:0]   req_b,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [NREQ-1:0]      rsp_err,
  output logic [31:0]          rsp_data,
  output logic [NREQ-1:0]      busy,
  output logic [OP_W-1:0]      alu_op,
  output logic [7:0]           alu_key,
  output logic [31:0]          alu_a,
  output logic [31:0]          alu_b,
  input  logic [31:0]          alu_out,
  input  logic [7:0]           alu_key_out
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [0:0] {StIdle, StWait} slotState_t;

  slotState_t       slotQ      [NREQ];
  slotState_t       slotD      [NREQ];
  logic [3:0]       tagQ       [NREQ];
  logic [3:0]       flightTagQ [NREQ];
  logic [CNT_W-1:0] wdCntQ     [NREQ];
  logic [2:0]       rrQ;

  logic [NREQ-1:0]  eligible;
  logic [NREQ-1:0]  matchHit;
  logic [NREQ-1:0]  timeoutHit;
  logic             grantValid;
  logic [2:0]       grantIdx;
  logic [3:0]       grantTag;
  logic [OP_W-1:0]  grantOp;
  logic [31:0]      grantA;
  logic [31:0]      grantB;

  // Search starts one past the last winner so every idle requester gets a turn.
  always_comb begin
    int idx;
    idx        = 0;
    eligible   = '0;
    grantValid = 1'b0;
    grantIdx   = '0;
    grantTag   = '0;
    grantOp    = '0;
    grantA     = '0;
    grantB     = '0;
    req_ready  = '0;
    for (int j = 0; j < NREQ; j++) begin
      eligible[j] = req_valid[j] && (slotQ[j] == StIdle);
    end
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(rrQ) + k) % NREQ;
      for (int j = 0; j < NREQ; j++) begin
        if (!grantValid && (j == idx) && eligible[j]) begin
          grantValid = 1'b1;
          grantIdx   = 3'(j);
        end
      end
    end
    for (int j = 0; j < NREQ; j++) begin
      if (grantValid && (grantIdx == 3'(j))) begin
        req_ready[j] = 1'b1;
        grantTag     = tagQ[j];
        grantOp      = req_op[j*OP_W +: OP_W];
        grantA       = req_a[j*32 +: 32];
        grantB       = req_b[j*32 +: 32];
      end
    end
  end

  // Bubbles, ids beyond NREQ and stale tags never match any slot.
  always_comb begin
    matchHit   = '0;
    timeoutHit = '0;
    for (int j = 0; j < NREQ; j++) begin
      matchHit[j]   = alu_key_out[7] && (alu_key_out[6:4] == 3'(j)) &&
                      (alu_key_out[3:0] == flightTagQ[j]) && (slotQ[j] == StWait);
      timeoutHit[j] = (slotQ[j] == StWait) && (wdCntQ[j] == WD_LAST) && !matchHit[j];
    end
  end

  always_comb begin
    for (int j = 0; j < NREQ; j++) begin
      slotD[j] = slotQ[j];
      case (slotQ[j])
        StIdle: if (req_ready[j]) slotD[j] = StWait;
        StWait: if (matchHit[j] || timeoutHit[j]) slotD[j] = StIdle;
        default: slotD[j] = StIdle;
      endcase
      busy[j] = (slotQ[j] == StWait);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < NREQ; j++) begin
        slotQ[j]      <= StIdle;
        tagQ[j]       <= '0;
        flightTagQ[j] <= '0;
        wdCntQ[j]     <= '0;
      end
      rrQ       <= 3'(NREQ - 1);
      rsp_valid <= '0;
      rsp_err   <= '0;
      rsp_data  <= '0;
      alu_op    <= '0;
      alu_key   <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
    end else begin
      for (int j = 0; j < NREQ; j++) begin
        slotQ[j] <= slotD[j];
        if (req_ready[j]) begin
          wdCntQ[j]     <= '0;
          flightTagQ[j] <= tagQ[j];
          tagQ[j]       <= tagQ[j] + 4'd1;
        end else if (slotQ[j] == StWait) begin
          wdCntQ[j] <= wdCntQ[j] + CNT_W'(1);
        end
      end
      rsp_valid <= matchHit | timeoutHit;
      rsp_err   <= timeoutHit;
      rsp_data  <= (|matchHit) ? alu_out : 32'h0;
      if (grantValid) begin
        rrQ     <= grantIdx;
        alu_op  <= grantOp;
        alu_a   <= grantA;
        alu_b   <= grantB;
        alu_key <= {1'b1, grantIdx, grantTag};
      end else begin
        alu_key <= 8'h00;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a 3-stage behavioural alu32 model.
// Drivers push expected keys/responses; a negedge monitor pops and compares.
module tb_alu_arbiter;

  localparam int NREQ    = 2;
  localparam int OP_W    = 4;
  localparam int TIMEOUT = 16;
  // Op encoding understood by the ALU model below.
  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_MUL = 4'h2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid, req_ready, rsp_valid, rsp_err, busy;
  logic [NREQ*4-1:0] req_op;
  logic [NREQ*32-1:0] req_a, req_b;
  logic [31:0]       rsp_data, alu_a, alu_b, alu_out;
  logic [3:0]        alu_op;
  logic [7:0]        alu_key, alu_key_out;

  alu_arbiter #(.NREQ(NREQ), .OP_W(OP_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_err(rsp_err),
    .rsp_data(rsp_data), .busy(busy), .alu_op(alu_op), .alu_key(alu_key), .alu_a(alu_a),
    .alu_b(alu_b), .alu_out(alu_out), .alu_key_out(alu_key_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ALU model: add, Q16.16 signed multiply, subtract otherwise.
  function automatic logic [31:0] aluCalc(logic [3:0] op, logic [31:0] a, logic [31:0] b);
    logic signed [63:0] p;
    case (op)
      OP_ADD: return a + b;
      OP_MUL: begin
        p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        return p[47:16];
      end
      default: return a - b;
    endcase
  endfunction

  logic [7:0]  pk [3] = '{default: 8'h00};
  logic [31:0] pd [3] = '{default: 32'h0};
  bit          blackhole = 1'b0;
  bit          injEn = 1'b0;
  logic [7:0]  injKey = 8'h00;
  logic [31:0] injData = 32'h0;

  always @(posedge clk) begin
    pk[0] <= blackhole ? 8'h00 : alu_key;
    pd[0] <= aluCalc(alu_op, alu_a, alu_b);
    pk[1] <= pk[0];
    pd[1] <= pd[0];
    pk[2] <= pk[1];
    pd[2] <= pd[1];
  end
  assign alu_key_out = injEn ? injKey : pk[2];
  assign alu_out     = injEn ? injData : pd[2];

  typedef struct {
    logic        err;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t       expQ0 [$];
  exp_t       expQ1 [$];
  logic [7:0] keyQ [$];
  int         grantLog [$];
  int         grantCyc [$];
  logic [3:0] tagModel [NREQ];
  int         nCmp = 0;
  int         nBad = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] req);
    nCmp++;
    if (act !== req) begin
      nBad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  function automatic void unexpected(string name, logic [31:0] act);
    nCmp++;
    nBad++;
    $display("FAIL %s: unexpected value %h with nothing expected (cycle %0d)", name, act, cyc);
  endfunction

  always @(negedge clk) begin
    exp_t e;
    bit   have;
    if (!rst) begin
      if (alu_key[7]) begin
        if (keyQ.size() == 0) unexpected("alu_key", {24'h0, alu_key});
        else check("alu_key", {24'h0, alu_key}, {24'h0, keyQ.pop_front()});
      end
      for (int i = 0; i < NREQ; i++) begin
        if (rsp_valid[i]) begin
          have = 1'b0;
          if (i == 0 && expQ0.size() > 0) begin
            e = expQ0.pop_front();
            have = 1'b1;
          end else if (i == 1 && expQ1.size() > 0) begin
            e = expQ1.pop_front();
            have = 1'b1;
          end
          if (!have) begin
            unexpected($sformatf("rsp_valid[%0d]", i), rsp_data);
          end else begin
            check($sformatf("rsp_err[%0d]", i), {31'h0, rsp_err[i]}, {31'h0, e.err});
            check($sformatf("rsp_data[%0d]", i), rsp_data, e.data);
            if (e.cyc >= 0) check($sformatf("rsp_cycle[%0d]", i), 32'(cyc), 32'(e.cyc));
          end
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the handshake edge.
  task automatic issue(input int i, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] expData, input bit expErr,
                       input bit pushRsp, input bit chkCyc);
    int   n;
    exp_t e;
    n = 0;
    req_op[i*4 +: 4] = op;
    req_a[i*32 +: 32] = a;
    req_b[i*32 +: 32] = b;
    req_valid[i] = 1'b1;
    @(negedge clk);
    while (!req_ready[i] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready[i]) begin
      unexpected($sformatf("ready_timeout[%0d]", i), 32'(n));
      req_valid[i] = 1'b0;
      return;
    end
    grantLog.push_back(i);
    grantCyc.push_back(cyc);
    keyQ.push_back({1'b1, 3'(i), tagModel[i]});
    tagModel[i] = tagModel[i] + 4'd1;
    if (pushRsp) begin
      e.err  = expErr;
      e.data = expData;
      e.cyc  = chkCyc ? cyc + TIMEOUT + 1 : -1;
      if (i == 0) expQ0.push_back(e);
      else expQ1.push_back(e);
    end
    @(posedge clk);
    #1 req_valid[i] = 1'b0;
  endtask

  task automatic inject(input logic [7:0] key, input logic [31:0] data);
    injKey  = key;
    injData = data;
    injEn   = 1'b1;
    @(posedge clk);
    #1 injEn = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((expQ0.size() != 0 || expQ1.size() != 0 || keyQ.size() != 0) && n < 300) begin
      @(posedge clk);
      n++;
    end
    if (n >= 300) unexpected("drain_timeout", 32'(expQ0.size() + expQ1.size() + keyQ.size()));
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic doReset(input int n);
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1 rst = 1'b0;
    tagModel = '{default: 4'h0};
  endtask

  initial begin
    logic [3:0] tOld, tNew;
    rst = 1'b1;
    req_valid = '0;
    req_op = '0;
    req_a = '0;
    req_b = '0;
    doReset(3);

    check("rst_busy", 32'(busy), 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_req_ready", 32'(req_ready), 32'h0);
    check("rst_alu_key", {24'h0, alu_key}, 32'h0);
    check("rst_rsp_data", rsp_data, 32'h0);

    // Single ADD on req0 gets key 8'h80.
    issue(0, OP_ADD, 32'h23456789, 32'h01fedcba, 32'h25444443, 1'b0, 1'b1, 1'b0);
    drain();
    // Q16.16 MUL on req1 gets key 8'h90.
    issue(1, OP_MUL, 32'hffc6b000, 32'hffd4d800, 32'h09a96480, 1'b0, 1'b1, 1'b0);
    drain();

    // Simultaneous requests straight after reset: req0 first, req1 one cycle later.
    doReset(4);
    grantLog.delete();
    grantCyc.delete();
    fork
      issue(0, OP_ADD, 32'h00000010, 32'h00000005, 32'h00000015, 1'b0, 1'b1, 1'b0);
      issue(1, OP_ADD, 32'h00000100, 32'h00000200, 32'h00000300, 1'b0, 1'b1, 1'b0);
    join
    drain();
    if (grantLog.size() == 2) begin
      check("t2_first_grant", 32'(grantLog[0]), 32'd0);
      check("t2_second_grant", 32'(grantLog[1]), 32'd1);
      check("t2_grant_gap", 32'(grantCyc[1] - grantCyc[0]), 32'd1);
    end else begin
      unexpected("t2_grant_count", 32'(grantLog.size()));
    end

    // Watchdog: result never returns, error pulse TIMEOUT+1 cycles after handshake.
    blackhole = 1'b1;
    issue(0, OP_ADD, 32'h1, 32'h2, 32'h0, 1'b1, 1'b1, 1'b1);
    tOld = tagModel[0] - 4'd1;
    drain();
    inject({1'b1, 3'd0, tOld}, 32'hdeadbeef);
    repeat (2) @(posedge clk);
    #1;
    issue(0, OP_ADD, 32'h5, 32'h6, 32'h0badf00d, 1'b0, 1'b1, 1'b0);
    tNew = tagModel[0] - 4'd1;
    inject({1'b1, 3'd0, tOld}, 32'hdeadbeef);
    inject({1'b1, 3'd5, tNew}, 32'hcafecafe);
    inject({1'b1, 3'd0, tNew}, 32'h0badf00d);
    drain();
    blackhole = 1'b0;
    check("t4_busy_after", 32'(busy), 32'h0);

    // Both held valid for 20 ops each: grants alternate, tags wrap.
    grantLog.delete();
    grantCyc.delete();
    fork
      for (int k = 0; k < 20; k++)
        issue(0, OP_ADD, 32'h00010000 + 32'(k), 32'(k * 3), 32'h00010000 + 32'(k * 4),
              1'b0, 1'b1, 1'b0);
      for (int k = 0; k < 20; k++)
        issue(1, OP_ADD, 32'h00020000 + 32'(k), 32'(k * 5), 32'h00020000 + 32'(k * 6),
              1'b0, 1'b1, 1'b0);
    join
    drain();
    check("t5_grant_count", 32'(grantLog.size()), 32'd40);
    for (int e = 1; e < grantLog.size(); e++)
      check("t5_alternate", 32'(grantLog[e]), 32'(1 - grantLog[e-1]));

    // Reset while both slots wait: ops are dropped, tags restart.
    fork
      issue(0, OP_ADD, 32'h7, 32'h8, 32'h0, 1'b0, 1'b0, 1'b0);
      issue(1, OP_ADD, 32'h9, 32'ha, 32'h0, 1'b0, 1'b0, 1'b0);
    join
    check("t6_busy_before", 32'(busy), 32'h3);
    @(posedge clk);
    #1;
    doReset(5);
    check("t6_busy_after", 32'(busy), 32'h0);
    repeat (6) @(posedge clk);
    #1;
    issue(0, OP_ADD, 32'h11111111, 32'h22222222, 32'h33333333, 1'b0, 1'b1, 1'b0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

endmodule
